// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: valid/ready handshake, 2-entry skid buffer, flush, NOP bubbles.
// Define ID_EX_PERF_CNT_EN to add saturating stall/bubble performance counters.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int EX_W   = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [M_W-1:0]    in_m,
    input  logic [EX_W-1:0]   in_ex,
    input  logic [DATA_W-1:0] in_npc,
    input  logic [DATA_W-1:0] in_rdata1,
    input  logic [DATA_W-1:0] in_rdata2,
    input  logic [DATA_W-1:0] in_simm,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [M_W-1:0]    out_m,
    output logic [EX_W-1:0]   out_ex,
    output logic [DATA_W-1:0] out_npc,
    output logic [DATA_W-1:0] out_rdata1,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [DATA_W-1:0] out_simm,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              perf_clr
`endif
);

    localparam int PW = WB_W + M_W + EX_W + 4 * DATA_W + 2 * REG_W;

    // Encoding bits are {main_valid, skid_valid}; the (0,1) combination is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   in_pkt;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic            main_valid;
    logic            skid_valid;
    logic            acc;
    logic            pop;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid;

    logic [WB_W-1:0] main_wb;
    logic [M_W-1:0]  main_m;
    logic [EX_W-1:0] main_ex;

    assign in_pkt = {in_wb, in_m, in_ex, in_npc, in_rdata1, in_rdata2, in_simm, in_rt, in_rd};

    assign main_valid = state_q[1];
    assign skid_valid = state_q[0];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign acc        = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_pkt;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pkt;
            end
        end
    end

    assign {main_wb, main_m, main_ex, out_npc, out_rdata1, out_rdata2, out_simm, out_rt, out_rd} = main_q;

    // Control fields collapse to a NOP whenever the slot is empty; data keeps its last value.
    assign out_wb = main_valid ? main_wb : '0;
    assign out_m  = main_valid ? main_m  : '0;
    assign out_ex = main_valid ? main_ex : '0;

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (out_ready && !out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; counter checks need ID_EX_PERF_CNT_EN.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wb;
    logic [2:0]  in_m;
    logic [3:0]  in_ex;
    logic [31:0] in_npc;
    logic [31:0] in_rdata1;
    logic [31:0] in_rdata2;
    logic [31:0] in_simm;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_wb;
    logic [2:0]  out_m;
    logic [3:0]  out_ex;
    logic [31:0] out_npc;
    logic [31:0] out_rdata1;
    logic [31:0] out_rdata2;
    logic [31:0] out_simm;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
`ifdef ID_EX_PERF_CNT_EN
    logic [3:0]  stall_cnt;
    logic [3:0]  bubble_cnt;
    logic        perf_clr;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_pipe_reg #(
        .DATA_W(32),
        .REG_W (5),
        .WB_W  (2),
        .M_W   (3),
        .EX_W  (4),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wb     (in_wb),
        .in_m      (in_m),
        .in_ex     (in_ex),
        .in_npc    (in_npc),
        .in_rdata1 (in_rdata1),
        .in_rdata2 (in_rdata2),
        .in_simm   (in_simm),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wb    (out_wb),
        .out_m     (out_m),
        .out_ex    (out_ex),
        .out_npc   (out_npc),
        .out_rdata1(out_rdata1),
        .out_rdata2(out_rdata2),
        .out_simm  (out_simm),
        .out_rt    (out_rt),
        .out_rd    (out_rd)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .perf_clr  (perf_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Payload derived from npc so every field is distinct per instruction.
    task automatic drive(input logic [31:0] npc);
        in_npc    = npc;
        in_rdata1 = npc ^ 32'hA5A5_0000;
        in_rdata2 = npc ^ 32'h0000_5A5A;
        in_simm   = ~npc;
        in_rt     = npc[6:2];
        in_rd     = ~npc[6:2];
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_wb     = 2'b11;
        in_m      = 3'b101;
        in_ex     = 4'b1010;
        drive(32'h0);
`ifdef ID_EX_PERF_CNT_EN
        perf_clr  = 1'b0;
`endif
        #3;
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h1);
        check("rst_npc", out_npc, 32'h0);
        check("rst_wb", {30'b0, out_wb}, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(32'h04);
        step();
        check("str0_npc", out_npc, 32'h04);
        check("str0_valid", {31'b0, out_valid}, 32'h1);
        check("str0_wb", {30'b0, out_wb}, 32'h3);
        check("str0_ex", {28'b0, out_ex}, 32'hA);
        check("str0_simm", out_simm, ~32'h04);
        drive(32'h08);
        step();
        check("str1_npc", out_npc, 32'h08);
        check("str1_ready", {31'b0, in_ready}, 32'h1);
        drive(32'h0C);
        step();
        check("str2_npc", out_npc, 32'h0C);
        check("str2_rdata1", out_rdata1, 32'hA5A5_000C);
        check("str2_rd", {27'b0, out_rd}, 32'h1C);
        check("str2_ready", {31'b0, in_ready}, 32'h1);

        // Bubbles: two idle cycles with EX ready
        in_valid = 1'b0;
        step();
        check("bub0_valid", {31'b0, out_valid}, 32'h0);
        check("bub0_ctrl", {23'b0, out_wb, out_m, out_ex}, 32'h0);
        check("bub0_npc_hold", out_npc, 32'h0C);
        step();
        check("bub1_valid", {31'b0, out_valid}, 32'h0);
        check("bub1_ctrl", {23'b0, out_wb, out_m, out_ex}, 32'h0);

        // Skid: A, B captured under back-pressure, C waits at input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(32'h10);
        step();
        check("skA_npc", out_npc, 32'h10);
        check("skA_ready", {31'b0, in_ready}, 32'h1);
        drive(32'h14);
        step();
        check("skB_npc", out_npc, 32'h10);
        check("skB_ready", {31'b0, in_ready}, 32'h0);
        drive(32'h18);
        step();
        check("skC_hold_npc", out_npc, 32'h10);
        check("skC_hold_ready", {31'b0, in_ready}, 32'h0);
        out_ready = 1'b1;
        step();
        check("skB_out", out_npc, 32'h14);
        check("skB_rdata2", out_rdata2, 32'h0000_5A4E);
        check("skB_ready1", {31'b0, in_ready}, 32'h1);
        step();
        check("skC_out", out_npc, 32'h18);
        check("skC_valid", {31'b0, out_valid}, 32'h1);
        in_valid = 1'b0;
        step();
        check("sk_drain", {31'b0, out_valid}, 32'h0);

        // Flush from TWO with a valid input in the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(32'h30);
        step();
        drive(32'h34);
        step();
        check("fl_two", {31'b0, in_ready}, 32'h0);
        flush = 1'b1;
        drive(32'h20);
        step();
        check("fl_valid", {31'b0, out_valid}, 32'h0);
        check("fl_ctrl", {23'b0, out_wb, out_m, out_ex}, 32'h0);
        check("fl_ready", {31'b0, in_ready}, 32'h1);
        check("fl_npc", out_npc, 32'h30);
        step();
        check("fl_empty_in", {31'b0, out_valid}, 32'h0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl_never_20", {31'b0, out_valid}, 32'h0);
        in_valid = 1'b1;
        drive(32'h40);
        step();
        check("fl_resume", out_npc, 32'h40);
        check("fl_resume_v", {31'b0, out_valid}, 32'h1);

        // Asynchronous reset mid-cycle while TWO is held
        out_ready = 1'b0;
        drive(32'h50);
        step();
        drive(32'h54);
        step();
        check("ar_two", {31'b0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'b0, out_valid}, 32'h0);
        check("ar_ex", {28'b0, out_ex}, 32'h0);
        check("ar_ready", {31'b0, in_ready}, 32'h1);
        check("ar_npc", out_npc, 32'h0);
        step();
        rst_n = 1'b1;

`ifdef ID_EX_PERF_CNT_EN
        check("pc_rst", {24'b0, stall_cnt, bubble_cnt}, 32'h0);
        drive(32'h60);
        step();
        step();
        check("pc_two", {31'b0, in_ready}, 32'h0);
        for (int unsigned i = 0; i < 5; i++) step();
        check("pc_stall5", {28'b0, stall_cnt}, 32'h5);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check("pc_clr", {28'b0, stall_cnt}, 32'h0);
        for (int unsigned i = 0; i < 20; i++) step();
        check("pc_sat", {28'b0, stall_cnt}, 32'hF);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        for (int unsigned i = 0; i < 3; i++) step();
        check("pc_bubble", {28'b0, bubble_cnt}, 32'h3);
        check("pc_flush_keep", {28'b0, stall_cnt}, 32'hF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
